tour_cmd: RTL and testbench

Downstream replay stage for the knight's-tour solver. After the solver asserts its done pulse, this block walks the stored move list by index. Each one-hot knight move becomes two movement commands: a vertical leg, then a horizontal leg. These commands go to the command processor through the same cmd/cmd_rdy interface the UART path uses. When no tour is running, the block is a transparent pass-through for UART commands.

---
 rtl/tour_pkg.sv | 34 +++
 rtl/move_decode.sv | 53 +++++
 rtl/tour_cmd.sv | 121 ++++++++++++
 tb/tb_tour_cmd.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour replay path:
// FSM states, command opcodes, headings, response bytes and move-bit indices.
package tour_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VERT   = 3'd1,
    ST_WAIT_V = 3'd2,
    ST_HORZ   = 3'd3,
    ST_WAIT_H = 3'd4
  } tour_state_t;

  localparam logic [3:0] OP_MOVE         = 4'h2;
  localparam logic [3:0] OP_MOVE_FANFARE = 4'h3;

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_W = 8'h3F;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_E = 8'hBF;

  localparam logic [7:0] RESP_FINAL = 8'hA5;
  localparam logic [7:0] RESP_MID   = 8'h5A;

  // Bit positions of the one-hot move word, named by (dx,dy)
  localparam int MV_B0 = 0;  // (+1,+2)
  localparam int MV_B1 = 1;  // (-1,+2)
  localparam int MV_B2 = 2;  // (-2,+1)
  localparam int MV_B3 = 3;  // (-2,-1)
  localparam int MV_B4 = 4;  // (-1,-2)
  localparam int MV_B5 = 5;  // (+1,-2)
  localparam int MV_B6 = 6;  // (+2,-1)
  localparam int MV_B7 = 7;  // (+2,+1)

endpackage

// File: rtl/move_decode.sv
// One-hot knight move to sign/magnitude of each leg. Lowest set bit wins;
// an all-zero move decodes to zero-length north/east legs.
module move_decode
  import tour_pkg::*;
(
  input  logic [7:0] move,
  output logic       dy_neg,
  output logic [1:0] dy_mag,
  output logic       dx_neg,
  output logic [1:0] dx_mag
);

  always_comb begin
    dy_neg = 1'b0;
    dy_mag = 2'd0;
    dx_neg = 1'b0;
    dx_mag = 2'd0;
    if (move[MV_B0]) begin
      dx_mag = 2'd1;
      dy_mag = 2'd2;
    end else if (move[MV_B1]) begin
      dx_neg = 1'b1;
      dx_mag = 2'd1;
      dy_mag = 2'd2;
    end else if (move[MV_B2]) begin
      dx_neg = 1'b1;
      dx_mag = 2'd2;
      dy_mag = 2'd1;
    end else if (move[MV_B3]) begin
      dx_neg = 1'b1;
      dx_mag = 2'd2;
      dy_neg = 1'b1;
      dy_mag = 2'd1;
    end else if (move[MV_B4]) begin
      dx_neg = 1'b1;
      dx_mag = 2'd1;
      dy_neg = 1'b1;
      dy_mag = 2'd2;
    end else if (move[MV_B5]) begin
      dx_mag = 2'd1;
      dy_neg = 1'b1;
      dy_mag = 2'd2;
    end else if (move[MV_B6]) begin
      dx_mag = 2'd2;
      dy_neg = 1'b1;
      dy_mag = 2'd1;
    end else if (move[MV_B7]) begin
      dx_mag = 2'd2;
      dy_mag = 2'd1;
    end
  end

endmodule

// File: rtl/tour_cmd.sv
// Replays the solved tour as vertical/horizontal command pairs to the command
// processor; transparent UART pass-through whenever no tour is running.
//
// state   | meaning
// IDLE    | UART pass-through, waiting for start_tour
// VERT    | presenting vertical leg, waiting for clr_cmd_rdy
// WAIT_V  | vertical leg executing, waiting for send_resp
// HORZ    | presenting horizontal leg, waiting for clr_cmd_rdy
// WAIT_H  | horizontal leg executing, waiting for send_resp
module tour_cmd
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

  tour_state_t state;
  logic        dy_neg, dx_neg;
  logic [1:0]  dy_mag, dx_mag;
  logic [15:0] vert_cmd, horz_cmd;
  logic        last_move;

  move_decode u_move_decode (
    .move   (move),
    .dy_neg (dy_neg),
    .dy_mag (dy_mag),
    .dx_neg (dx_neg),
    .dx_mag (dx_mag)
  );

  assign last_move = (mv_indx == LAST_INDX);
  assign vert_cmd  = {OP_MOVE, (dy_neg ? HEAD_S : HEAD_N), 2'b00, dy_mag};
  assign horz_cmd  = {OP_MOVE_FANFARE, (dx_neg ? HEAD_W : HEAD_E), 2'b00, dx_mag};

  // mv_indx only moves on WAIT_H -> VERT, so cmd is stable while cmd_rdy is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      mv_indx <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_tour) begin
            state   <= ST_VERT;
            mv_indx <= 5'd0;
          end
        end
        ST_VERT: begin
          if (clr_cmd_rdy) state <= ST_WAIT_V;
        end
        ST_WAIT_V: begin
          if (send_resp) state <= ST_HORZ;
        end
        ST_HORZ: begin
          if (clr_cmd_rdy) state <= ST_WAIT_H;
        end
        ST_WAIT_H: begin
          if (send_resp) begin
            if (last_move) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_VERT;
              mv_indx <= mv_indx + 5'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_MID;
    case (state)
      ST_IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_FINAL;
      end
      ST_VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
      end
      ST_WAIT_V: begin
        cmd = vert_cmd;
      end
      ST_HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
      end
      ST_WAIT_H: begin
        cmd  = horz_cmd;
        resp = last_move ? RESP_FINAL : RESP_MID;
      end
      default: begin
        cmd     = cmd_UART;
        cmd_rdy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_tour_cmd.sv
// Self-checking bench for tour_cmd: solver memory model, command-processor
// handshake and a queue of expected commands built from the move table.
module tb_tour_cmd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  logic [7:0]  mem [24];
  logic [15:0] exp_q [$];
  int          n_pass = 0;
  int          n_total = 0;

  int dx_t [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int dy_t [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  always #5 clk = ~clk;

  assign move = (mv_indx < 5'd24) ? mem[mv_indx] : 8'h00;

  tour_cmd #(.NUM_MOVES(24)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp)
  );

  // Scanning high to low leaves the lowest set bit's displacement in place
  function automatic logic [15:0] exp_vert(input logic [7:0] m);
    int dy = 0;
    for (int i = 7; i >= 0; i--) if (m[i]) dy = dy_t[i];
    if (dy < 0) return {4'h2, 8'h7F, 4'(-dy)};
    return {4'h2, 8'h00, 4'(dy)};
  endfunction

  function automatic logic [15:0] exp_horz(input logic [7:0] m);
    int dx = 0;
    for (int i = 7; i >= 0; i--) if (m[i]) dx = dx_t[i];
    if (dx < 0) return {4'h3, 8'h3F, 4'(-dx)};
    return {4'h3, 8'hBF, 4'(dx)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
  endtask

  task automatic serve(input logic [7:0] wait_resp, input string tag);
    logic [15:0] e;
    int n = 0;
    while (cmd_rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (cmd_rdy !== 1'b1) $display("FAIL %s_rdy timeout cmd_rdy=%b want 1", tag, cmd_rdy);
    else n_pass++;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s_cmd got %h want <queue empty>", tag, cmd);
    end else begin
      e = exp_q.pop_front();
      if (cmd !== e) $display("FAIL %s_cmd got %h want %h", tag, cmd, e);
      else n_pass++;
    end
    clr_cmd_rdy = 1'b1;
    #1;
    n_total++;
    if (clr_cmd_rdy_UART !== 1'b0) $display("FAIL %s_uart_ack got %b want 0", tag, clr_cmd_rdy_UART);
    else n_pass++;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    n_total++;
    if (cmd_rdy !== 1'b0) $display("FAIL %s_wait_rdy got %b want 0", tag, cmd_rdy);
    else n_pass++;
    n_total++;
    if (resp !== wait_resp) $display("FAIL %s_resp got %h want %h", tag, resp, wait_resp);
    else n_pass++;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_UART = 16'h1234;
    cmd_rdy_UART = 1'b1;
    clr_cmd_rdy = 1'b0;
    #1;
    n_total++;
    if (mv_indx !== 5'd0) $display("FAIL rst_indx got %0d want 0", mv_indx); else n_pass++;
    n_total++;
    if (resp !== 8'hA5) $display("FAIL rst_resp got %h want a5", resp); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (cmd !== 16'h1234) $display("FAIL idle_cmd got %h want 1234", cmd); else n_pass++;
    n_total++;
    if (cmd_rdy !== 1'b1) $display("FAIL idle_rdy got %b want 1", cmd_rdy); else n_pass++;
    clr_cmd_rdy = 1'b1;
    #1;
    n_total++;
    if (clr_cmd_rdy_UART !== 1'b1) $display("FAIL idle_ack got %b want 1", clr_cmd_rdy_UART); else n_pass++;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    cmd_rdy_UART = 1'b0;
    #1;
    n_total++;
    if (clr_cmd_rdy_UART !== 1'b0 || cmd_rdy !== 1'b0)
      $display("FAIL idle_release got ack=%b rdy=%b want 0 0", clr_cmd_rdy_UART, cmd_rdy);
    else n_pass++;
  endtask

  task automatic test_single_b0();
    do_reset();
    mem[0] = 8'b0000_0001;
    exp_q.push_back(16'h2002);
    exp_q.push_back(16'h3BF1);
    pulse_start();
    n_total++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h2002)
      $display("FAIL b0_latency got rdy=%b cmd=%h want 1 2002", cmd_rdy, cmd);
    else n_pass++;
    serve(8'h5A, "b0_v");
    n_total++;
    if (resp !== 8'h5A) $display("FAIL b0_resp_after got %h want 5a", resp); else n_pass++;
    serve(8'h5A, "b0_h");
  endtask

  task automatic test_b3_indx();
    do_reset();
    mem[0] = 8'b0000_1000;
    exp_q.push_back(exp_vert(mem[0]));
    exp_q.push_back(exp_horz(mem[0]));
    pulse_start();
    serve(8'h5A, "b3_v");
    n_total++;
    if (mv_indx !== 5'd0) $display("FAIL b3_indx_mid got %0d want 0", mv_indx); else n_pass++;
    serve(8'h5A, "b3_h");
    n_total++;
    if (mv_indx !== 5'd1) $display("FAIL b3_indx_next got %0d want 1", mv_indx); else n_pass++;
  endtask

  task automatic test_full_replay();
    do_reset();
    for (int i = 0; i < 24; i++) mem[i] = 8'h01 << $urandom_range(0, 7);
    mem[5] = 8'h00;
    mem[7] = 8'b1010_0100;
    mem[13] = 8'b1111_1000;
    cmd_UART = 16'hBEEF;
    cmd_rdy_UART = 1'b1;
    for (int i = 0; i < 24; i++) begin
      exp_q.push_back(exp_vert(mem[i]));
      exp_q.push_back(exp_horz(mem[i]));
    end
    pulse_start();
    for (int k = 0; k < 24; k++) begin
      serve(8'h5A, "full_v");
      serve((k == 23) ? 8'hA5 : 8'h5A, "full_h");
    end
    n_total++;
    if (mv_indx !== 5'd23) $display("FAIL full_end_indx got %0d want 23", mv_indx); else n_pass++;
    n_total++;
    if (cmd !== 16'hBEEF || cmd_rdy !== 1'b1 || resp !== 8'hA5)
      $display("FAIL full_end_idle got cmd=%h rdy=%b resp=%h want beef 1 a5", cmd, cmd_rdy, resp);
    else n_pass++;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL full_leftover got %0d want 0", exp_q.size()); else n_pass++;
    cmd_rdy_UART = 1'b0;
  endtask

  task automatic test_abuse();
    do_reset();
    mem[0] = 8'b0010_0000;
    mem[1] = 8'b0100_0000;
    cmd_UART = 16'hBEEF;
    cmd_rdy_UART = 1'b1;
    exp_q.push_back(exp_vert(mem[0]));
    exp_q.push_back(exp_horz(mem[0]));
    pulse_start();
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    n_total++;
    if (cmd_rdy !== 1'b1 || cmd !== exp_q[0])
      $display("FAIL ab_resp_in_vert got rdy=%b cmd=%h want 1 %h", cmd_rdy, cmd, exp_q[0]);
    else n_pass++;
    clr_cmd_rdy = 1'b1;
    send_resp = 1'b1;
    #1;
    n_total++;
    if (clr_cmd_rdy_UART !== 1'b0) $display("FAIL ab_uart_ack got %b want 0", clr_cmd_rdy_UART); else n_pass++;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    void'(exp_q.pop_front());
    n_total++;
    if (cmd_rdy !== 1'b0) $display("FAIL ab_clr_and_resp got rdy=%b want 0", cmd_rdy); else n_pass++;
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    n_total++;
    if (cmd_rdy !== 1'b0) $display("FAIL ab_clr_in_wait got rdy=%b want 0", cmd_rdy); else n_pass++;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    n_total++;
    if (cmd_rdy !== 1'b1 || cmd !== exp_q[0])
      $display("FAIL ab_horz got rdy=%b cmd=%h want 1 %h", cmd_rdy, cmd, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
    n_total++;
    if (cmd_rdy !== 1'b0 || mv_indx !== 5'd0)
      $display("FAIL ab_start_in_waith got rdy=%b indx=%0d want 0 0", cmd_rdy, mv_indx);
    else n_pass++;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    n_total++;
    if (mv_indx !== 5'd1 || cmd_rdy !== 1'b1 || cmd !== exp_vert(mem[1]))
      $display("FAIL ab_next got indx=%0d rdy=%b cmd=%h want 1 1 %h", mv_indx, cmd_rdy, cmd, exp_vert(mem[1]));
    else n_pass++;
    cmd_rdy_UART = 1'b0;
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int i = 0; i < 24; i++) mem[i] = 8'h01 << $urandom_range(0, 7);
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(exp_vert(mem[i]));
      exp_q.push_back(exp_horz(mem[i]));
    end
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      serve(8'h5A, "rm_v");
      serve(8'h5A, "rm_h");
    end
    serve(8'h5A, "rm_v10");
    n_total++;
    if (mv_indx !== 5'd10 || cmd_rdy !== 1'b1 || cmd !== exp_horz(mem[10]))
      $display("FAIL rm_in_horz got indx=%0d rdy=%b cmd=%h want 10 1 %h", mv_indx, cmd_rdy, cmd, exp_horz(mem[10]));
    else n_pass++;
    rst = 1'b1;
    exp_q.delete();
    #1;
    n_total++;
    if (mv_indx !== 5'd0 || cmd_rdy !== 1'b0 || resp !== 8'hA5)
      $display("FAIL rm_async got indx=%0d rdy=%b resp=%h want 0 0 a5", mv_indx, cmd_rdy, resp);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (cmd_rdy !== 1'b0) $display("FAIL rm_no_reissue got rdy=%b want 0", cmd_rdy); else n_pass++;
    pulse_start();
    n_total++;
    if (mv_indx !== 5'd0 || cmd_rdy !== 1'b1 || cmd !== exp_vert(mem[0]))
      $display("FAIL rm_restart got indx=%0d rdy=%b cmd=%h want 0 1 %h", mv_indx, cmd_rdy, cmd, exp_vert(mem[0]));
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    start_tour = 1'b0;
    send_resp = 1'b0;
    clr_cmd_rdy = 1'b0;
    cmd_UART = 16'h0000;
    cmd_rdy_UART = 1'b0;
    for (int i = 0; i < 24; i++) mem[i] = 8'h00;
    test_reset();
    test_single_b0();
    test_b3_indx();
    test_full_replay();
    test_abuse();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
